thunder_tod_keeper: RTL and testbench

//  Consumes decoded 8F-AB time fields from the Thunderbolt UART interface and the GPS 1PPS pin.

---
 rtl/thunder_tod_keeper.sv | 233 +++++++++++++++++++++++
 tb/tb_thunder_tod_keeper.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/thunder_tod_keeper.sv
// UTC time-of-day keeper: advances on GPS 1PPS, re-syncs from Thunderbolt 8F-AB packets.
// Optional PPS-loss HOLDOVER state is built when THUNDER_TOD_PPS_TIMEOUT_EN is defined.
module thunder_tod_keeper #(
    parameter int c_MISMATCH_W  = 8,
    parameter int c_PPS_TIMEOUT = 15_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_pps,
    input  logic                    i_thunder_packet_dv,
    input  logic [7:0]              i_thunder_year_h,
    input  logic [7:0]              i_thunder_year_l,
    input  logic [7:0]              i_thunder_month,
    input  logic [7:0]              i_thunder_day,
    input  logic [7:0]              i_thunder_hour,
    input  logic [7:0]              i_thunder_minutes,
    input  logic [7:0]              i_thunder_seconds,
    output logic [15:0]             o_tod_year,
    output logic [7:0]              o_tod_month,
    output logic [7:0]              o_tod_day,
    output logic [7:0]              o_tod_hour,
    output logic [7:0]              o_tod_minutes,
    output logic [7:0]              o_tod_seconds,
    output logic                    o_tod_valid,
    output logic                    o_tod_tick,
    output logic [c_MISMATCH_W-1:0] o_mismatch_cnt,
    output logic [c_MISMATCH_W-1:0] o_bad_pkt_cnt
);

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minutes;
        logic [7:0]  seconds;
    } tod_t;

`ifdef THUNDER_TOD_PPS_TIMEOUT_EN
    typedef enum logic [1:0] {UNSYNC, LOCKED, HOLDOVER} state_t;
`else
    typedef enum logic [1:0] {UNSYNC, LOCKED} state_t;
`endif

    if (c_MISMATCH_W < 1 || c_PPS_TIMEOUT < 1) begin : g_cfg_check
        $error("thunder_tod_keeper: c_MISMATCH_W and c_PPS_TIMEOUT must be positive");
    end

    state_t                  state;
    tod_t                    tod;
    tod_t                    pkt;
    logic                    pkt_in_range;
    logic                    pkt_good;
    logic                    tod_valid;
    logic                    tick;
    logic [c_MISMATCH_W-1:0] mismatch_cnt;
    logic [c_MISMATCH_W-1:0] bad_pkt_cnt;
    logic                    pps_p0;
    logic                    pps_p1;
    logic                    pps_p2;
    logic                    pps_edge;

    function automatic logic [7:0] days_in_month(input logic [15:0] year, input logic [7:0] month);
        logic [7:0] d;
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
            8'd2:                    d = (year[1:0] == 2'b00) ? 8'd29 : 8'd28;
            default:                 d = 8'd31;
        endcase
        return d;
    endfunction

    // One-second advance with full calendar carry; day >= month length wraps to the 1st.
    function automatic tod_t tod_inc(input tod_t t);
        tod_t r;
        r = t;
        if (t.seconds < 8'd59) begin
            r.seconds = t.seconds + 8'd1;
        end else begin
            r.seconds = 8'd0;
            if (t.minutes < 8'd59) begin
                r.minutes = t.minutes + 8'd1;
            end else begin
                r.minutes = 8'd0;
                if (t.hour < 8'd23) begin
                    r.hour = t.hour + 8'd1;
                end else begin
                    r.hour = 8'd0;
                    if (t.day < days_in_month(t.year, t.month)) begin
                        r.day = t.day + 8'd1;
                    end else begin
                        r.day = 8'd1;
                        if (t.month < 8'd12) begin
                            r.month = t.month + 8'd1;
                        end else begin
                            r.month = 8'd1;
                            r.year  = t.year + 16'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic logic [c_MISMATCH_W-1:0] sat_inc(input logic [c_MISMATCH_W-1:0] v);
        return (&v) ? v : v + {{(c_MISMATCH_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic range_ok(input tod_t t);
        return (t.month != 8'd0) && (t.month <= 8'd12) &&
               (t.day != 8'd0) && (t.day <= 8'd31) &&
               (t.hour <= 8'd23) && (t.minutes <= 8'd59) && (t.seconds <= 8'd59);
    endfunction

    always_comb begin
        pkt.year     = {i_thunder_year_h, i_thunder_year_l};
        pkt.month    = i_thunder_month;
        pkt.day      = i_thunder_day;
        pkt.hour     = i_thunder_hour;
        pkt.minutes  = i_thunder_minutes;
        pkt.seconds  = i_thunder_seconds;
        pkt_in_range = range_ok(pkt);
        pkt_good     = i_thunder_packet_dv && pkt_in_range;
    end

    // PPS: p0/p1 resynchronise the async pin, p2 holds the previous level for edge detect
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pps_p0 <= 1'b0;
            pps_p1 <= 1'b0;
            pps_p2 <= 1'b0;
        end else begin
            pps_p0 <= i_pps;
            pps_p1 <= pps_p0;
            pps_p2 <= pps_p1;
        end
    end

    assign pps_edge = pps_p1 && !pps_p2;

`ifdef THUNDER_TOD_PPS_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(c_PPS_TIMEOUT + 1);
    logic [c_TMO_W-1:0] tmo_cnt;
    logic               tmo_hit;

    // A fresh packet also restarts the window so a late first lock does not drop straight to HOLDOVER
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt <= '0;
        end else if (pps_edge || pkt_good) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + c_TMO_W'(1);
        end
    end

    assign tmo_hit = (tmo_cnt == c_TMO_W'(c_PPS_TIMEOUT));
`endif

    // Time-of-day state machine; tod, tick and valid are all registered here
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= UNSYNC;
            tod          <= '0;
            tod_valid    <= 1'b0;
            tick         <= 1'b0;
            mismatch_cnt <= '0;
            bad_pkt_cnt  <= '0;
        end else begin
            tick <= 1'b0;
            if (i_thunder_packet_dv && !pkt_in_range) begin
                bad_pkt_cnt <= sat_inc(bad_pkt_cnt);
            end
            case (state)
                UNSYNC: begin
                    if (pkt_good) begin
                        tod       <= pkt;
                        state     <= LOCKED;
                        tod_valid <= 1'b1;
                    end
                end
                LOCKED: begin
                    tick <= pps_edge;
                    if (pkt_good) begin
                        if (pkt != tod) begin
                            mismatch_cnt <= sat_inc(mismatch_cnt);
                        end
                        tod <= pps_edge ? tod_inc(pkt) : pkt;
                    end else if (pps_edge) begin
                        tod <= tod_inc(tod);
                    end
`ifdef THUNDER_TOD_PPS_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state     <= HOLDOVER;
                        tod_valid <= 1'b0;
                    end
`endif
                end
`ifdef THUNDER_TOD_PPS_TIMEOUT_EN
                HOLDOVER: begin
                    if (pkt_good || pps_edge) begin
                        tick      <= pps_edge;
                        state     <= LOCKED;
                        tod_valid <= 1'b1;
                        if (pkt_good) begin
                            tod <= pps_edge ? tod_inc(pkt) : pkt;
                        end else begin
                            tod <= tod_inc(tod);
                        end
                    end
                end
`endif
                default: begin
                    state     <= UNSYNC;
                    tod_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_tod_year     = tod.year;
    assign o_tod_month    = tod.month;
    assign o_tod_day      = tod.day;
    assign o_tod_hour     = tod.hour;
    assign o_tod_minutes  = tod.minutes;
    assign o_tod_seconds  = tod.seconds;
    assign o_tod_valid    = tod_valid;
    assign o_tod_tick     = tick;
    assign o_mismatch_cnt = mismatch_cnt;
    assign o_bad_pkt_cnt  = bad_pkt_cnt;

endmodule

// File: tb/tb_thunder_tod_keeper.sv
// Directed bench for thunder_tod_keeper; HOLDOVER checks run when THUNDER_TOD_PPS_TIMEOUT_EN is defined.
module tb_thunder_tod_keeper;

`ifdef THUNDER_TOD_PPS_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 15_000_000;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_pps = 1'b0;
    logic        i_thunder_packet_dv = 1'b0;
    logic [7:0]  i_thunder_year_h = '0, i_thunder_year_l = '0;
    logic [7:0]  i_thunder_month = '0, i_thunder_day = '0, i_thunder_hour = '0;
    logic [7:0]  i_thunder_minutes = '0, i_thunder_seconds = '0;
    logic [15:0] o_tod_year;
    logic [7:0]  o_tod_month, o_tod_day, o_tod_hour, o_tod_minutes, o_tod_seconds;
    logic        o_tod_valid, o_tod_tick;
    logic [7:0]  o_mismatch_cnt, o_bad_pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    thunder_tod_keeper #(.c_MISMATCH_W(8), .c_PPS_TIMEOUT(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_pps(i_pps),
        .i_thunder_packet_dv(i_thunder_packet_dv),
        .i_thunder_year_h(i_thunder_year_h), .i_thunder_year_l(i_thunder_year_l),
        .i_thunder_month(i_thunder_month), .i_thunder_day(i_thunder_day),
        .i_thunder_hour(i_thunder_hour), .i_thunder_minutes(i_thunder_minutes),
        .i_thunder_seconds(i_thunder_seconds),
        .o_tod_year(o_tod_year), .o_tod_month(o_tod_month), .o_tod_day(o_tod_day),
        .o_tod_hour(o_tod_hour), .o_tod_minutes(o_tod_minutes), .o_tod_seconds(o_tod_seconds),
        .o_tod_valid(o_tod_valid), .o_tod_tick(o_tod_tick),
        .o_mismatch_cnt(o_mismatch_cnt), .o_bad_pkt_cnt(o_bad_pkt_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input int y, input int mo, input int d,
                                       input int h, input int mi, input int s);
        logic [15:0] yy;
        logic [7:0]  m8, d8, h8, mi8, s8;
        yy = 16'(y); m8 = 8'(mo); d8 = 8'(d); h8 = 8'(h); mi8 = 8'(mi); s8 = 8'(s);
        return {8'h00, yy, m8, d8, h8, mi8, s8};
    endfunction

    function automatic logic [63:0] tod_now();
        return {8'h00, o_tod_year, o_tod_month, o_tod_day, o_tod_hour, o_tod_minutes, o_tod_seconds};
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) step();
        i_rst = 1'b0;
        step();
    endtask

    task automatic set_fields(input int y, input int mo, input int d,
                              input int h, input int mi, input int s);
        logic [15:0] yy;
        yy = 16'(y);
        i_thunder_year_h  = yy[15:8];
        i_thunder_year_l  = yy[7:0];
        i_thunder_month   = 8'(mo);
        i_thunder_day     = 8'(d);
        i_thunder_hour    = 8'(h);
        i_thunder_minutes = 8'(mi);
        i_thunder_seconds = 8'(s);
    endtask

    task automatic send_pkt(input int y, input int mo, input int d,
                            input int h, input int mi, input int s);
        set_fields(y, mo, d, h, mi, s);
        i_thunder_packet_dv = 1'b1;
        step();
        i_thunder_packet_dv = 1'b0;
    endtask

    // Tick must appear exactly on the third clock after the pin rises, for one cycle
    task automatic pps_pulse(input logic exp_tick);
        i_pps = 1'b1;
        repeat (2) step();
        chk("tick_early", {63'd0, o_tod_tick}, 64'd0);
        step();
        chk("tick_at_3", {63'd0, o_tod_tick}, {63'd0, exp_tick});
        step();
        chk("tick_1cyc", {63'd0, o_tod_tick}, 64'd0);
        i_pps = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        // 1: reset state, PPS ignored while unsynchronised
        i_rst = 1'b1;
        #1;
        chk("rst_tod", tod_now(), 64'd0);
        chk("rst_valid", {63'd0, o_tod_valid}, 64'd0);
        chk("rst_cnts", {48'd0, o_mismatch_cnt, o_bad_pkt_cnt}, 64'd0);
        do_reset();
        for (int i = 0; i < 3; i++) pps_pulse(1'b0);
        chk("unsync_tod", tod_now(), 64'd0);
        chk("unsync_valid", {63'd0, o_tod_valid}, 64'd0);

        // 2: leap-day rollover and a following second
        send_pkt(2024, 2, 28, 23, 59, 59);
        chk("load_leap", tod_now(), mk(2024, 2, 28, 23, 59, 59));
        chk("locked_valid", {63'd0, o_tod_valid}, 64'd1);
        pps_pulse(1'b1);
        chk("leap_day", tod_now(), mk(2024, 2, 29, 0, 0, 0));
        pps_pulse(1'b1);
        chk("leap_next", tod_now(), mk(2024, 2, 29, 0, 0, 1));

        // 3: year, non-leap February and 30-day month rollovers
        do_reset();
        send_pkt(2023, 12, 31, 23, 59, 59);
        pps_pulse(1'b1);
        chk("new_year", tod_now(), mk(2024, 1, 1, 0, 0, 0));
        do_reset();
        send_pkt(2023, 2, 28, 23, 59, 59);
        pps_pulse(1'b1);
        chk("nonleap_feb", tod_now(), mk(2023, 3, 1, 0, 0, 0));
        do_reset();
        send_pkt(2024, 4, 30, 23, 59, 59);
        pps_pulse(1'b1);
        chk("april_end", tod_now(), mk(2024, 5, 1, 0, 0, 0));

        // 4: mismatch counting
        do_reset();
        send_pkt(2024, 6, 15, 10, 0, 5);
        chk("mism_init", {56'd0, o_mismatch_cnt}, 64'd0);
        send_pkt(2024, 6, 15, 10, 0, 7);
        chk("mism_one", {56'd0, o_mismatch_cnt}, 64'd1);
        chk("mism_reload", tod_now(), mk(2024, 6, 15, 10, 0, 7));
        send_pkt(2024, 6, 15, 10, 0, 7);
        chk("mism_match", {56'd0, o_mismatch_cnt}, 64'd1);

        // 5: range check, then packet coinciding with the PPS edge
        send_pkt(2024, 13, 15, 10, 0, 0);
        chk("bad_month", {56'd0, o_bad_pkt_cnt}, 64'd1);
        chk("bad_tod_kept", tod_now(), mk(2024, 6, 15, 10, 0, 7));
        chk("bad_valid", {63'd0, o_tod_valid}, 64'd1);
        chk("bad_no_mism", {56'd0, o_mismatch_cnt}, 64'd1);
        send_pkt(2024, 6, 15, 10, 0, 60);
        chk("bad_sec", {56'd0, o_bad_pkt_cnt}, 64'd2);
        i_pps = 1'b1;
        repeat (2) step();
        set_fields(2024, 6, 15, 12, 0, 0);
        i_thunder_packet_dv = 1'b1;
        step();
        i_thunder_packet_dv = 1'b0;
        chk("sim_tod", tod_now(), mk(2024, 6, 15, 12, 0, 1));
        chk("sim_tick", {63'd0, o_tod_tick}, 64'd1);
        chk("sim_mism", {56'd0, o_mismatch_cnt}, 64'd2);
        i_pps = 1'b0;
        repeat (3) step();

        do_reset();
        send_pkt(2024, 1, 0, 0, 0, 0);
        chk("unsync_bad", {56'd0, o_bad_pkt_cnt}, 64'd1);
        chk("unsync_bad_valid", {63'd0, o_tod_valid}, 64'd0);
        set_fields(2024, 1, 1, 24, 0, 0);
        i_thunder_packet_dv = 1'b1;
        repeat (260) step();
        i_thunder_packet_dv = 1'b0;
        chk("bad_saturate", {56'd0, o_bad_pkt_cnt}, 64'd255);

        // 6: PPS loss behaviour and asynchronous reset
        do_reset();
        send_pkt(2024, 3, 1, 8, 0, 0);
        pps_pulse(1'b1);
        repeat (TMO == 100 ? 120 : 150) step();
`ifdef THUNDER_TOD_PPS_TIMEOUT_EN
        chk("hold_valid", {63'd0, o_tod_valid}, 64'd0);
        chk("hold_frozen", tod_now(), mk(2024, 3, 1, 8, 0, 1));
        pps_pulse(1'b1);
        chk("relock_valid", {63'd0, o_tod_valid}, 64'd1);
        chk("relock_tod", tod_now(), mk(2024, 3, 1, 8, 0, 2));
        repeat (120) step();
        chk("hold_again", {63'd0, o_tod_valid}, 64'd0);
`else
        chk("no_hold_valid", {63'd0, o_tod_valid}, 64'd1);
        chk("no_hold_tod", tod_now(), mk(2024, 3, 1, 8, 0, 1));
`endif
        i_rst = 1'b1;
        #2;
        chk("async_rst_tod", tod_now(), 64'd0);
        chk("async_rst_valid", {63'd0, o_tod_valid}, 64'd0);
        chk("async_rst_cnts", {48'd0, o_mismatch_cnt, o_bad_pkt_cnt}, 64'd0);
        step();
        i_rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
